// File: rtl/sync_fifo_flags_if.sv
// Push/pop bus for sync_fifo_flags: write request side, FWFT read side,
// occupancy flags and sticky error flags.
interface sync_fifo_flags_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BITS  = 64
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Handshake: push is accepted on a rising clk when the FIFO is not full, or when
  // a pop is accepted in the same cycle; d is captured then. pop is accepted when
  // the FIFO is not empty and consumes the word currently on q. flush overrides both.
  logic            flush;
  logic            push;
  logic [BITS-1:0] d;
  logic            pop;
  logic [BITS-1:0] q;
  logic            full;
  logic            empty;
  logic            almost_full;
  logic            almost_empty;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            underflow;

  modport master (
    output flush, push, d, pop,
    input  q, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, push, d, pop,
    output q, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock first-word-fall-through FIFO with count-derived flags,
// programmable almost thresholds, synchronous flush and sticky error flags.
module sync_fifo_flags #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned BITS      = 64,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_fifo_flags_if.slave   bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic empty, full, push_ok, pop_ok;

  // Full/empty come from the occupancy count, never from pointer equality.
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = bus.pop & ~empty;
  assign push_ok = bus.push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (bus.push && !push_ok) overflow_d  = 1'b1;
      if (bus.pop && empty)     underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; only the control state above does.
  always_ff @(posedge clk) begin
    if (!bus.flush && push_ok) mem_q[wr_ptr_q] <= bus.d;
  end

  assign bus.q            = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised and directed bench for sync_fifo_flags against a queue-based
// reference model; popped words are checked through an expected-value queue.
module tb_sync_fifo_flags;
  localparam int DEPTH = 8;
  localparam int BITS  = 64;
  localparam int AF    = 6;
  localparam int AE    = 1;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DEPTH(DEPTH), .BITS(BITS)) bus();

  sync_fifo_flags #(
    .DEPTH(DEPTH), .BITS(BITS), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [BITS-1:0] exp_q[$];
  logic [BITS-1:0] ref_q[$];
  bit ref_ovf, ref_unf;
  bit mon_en = 1'b0;
  int n_vec  = 0;
  int n_err  = 0;

  task automatic check(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    int sz;
    logic [BITS-1:0] head;
    sz   = ref_q.size();
    head = (sz > 0) ? ref_q[0] : '0;
    check({tag, ".count"},        BITS'(bus.count),        BITS'(sz));
    check({tag, ".empty"},        BITS'(bus.empty),        BITS'(sz == 0));
    check({tag, ".full"},         BITS'(bus.full),         BITS'(sz == DEPTH));
    check({tag, ".almost_full"},  BITS'(bus.almost_full),  BITS'(sz >= AF));
    check({tag, ".almost_empty"}, BITS'(bus.almost_empty), BITS'(sz <= AE));
    check({tag, ".overflow"},     BITS'(bus.overflow),     BITS'(ref_ovf));
    check({tag, ".underflow"},    BITS'(bus.underflow),    BITS'(ref_unf));
    check({tag, ".q"},            bus.q,                   head);
  endtask

  // monitor: inputs settle at posedge+2, so negedge sees stable state and requests
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check_status("status");
      if (bus.pop && !bus.flush && !bus.empty) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pop_data: got 0x%0h, expected no pop output at %0t", bus.q, $time);
        end else begin
          check("pop_data", bus.q, exp_q.pop_front());
        end
      end
    end
  end

  // driver: called at posedge+2, applies one cycle, advances the model at the edge
  task automatic drive(input bit fl, input bit pu, input logic [BITS-1:0] dd, input bit po);
    int sz;
    bit popped;
    sz = ref_q.size();
    bus.flush = fl;
    bus.push  = pu;
    bus.d     = dd;
    bus.pop   = po;
    popped = !fl && po && (sz > 0);
    if (popped) exp_q.push_back(ref_q[0]);
    @(posedge clk);
    if (fl) begin
      ref_q.delete();
      ref_ovf = 1'b0;
      ref_unf = 1'b0;
    end else begin
      if (po && sz == 0) ref_unf = 1'b1;
      if (popped) void'(ref_q.pop_front());
      if (pu) begin
        if (sz < DEPTH || popped) ref_q.push_back(dd);
        else ref_ovf = 1'b1;
      end
    end
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic push_val(input logic [BITS-1:0] v);
    drive(1'b0, 1'b1, v, 1'b0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic fill_11_88();
    logic [BITS-1:0] v;
    for (int i = 1; i <= DEPTH; i++) begin
      v = BITS'(i * 'h11);
      push_val(v);
    end
  endtask

  // mid-cycle asynchronous reset with immediate output checks
  task automatic async_reset();
    bus.flush = 1'b0;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.d     = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst.count",        BITS'(bus.count),        '0);
    check("rst.empty",        BITS'(bus.empty),        BITS'(1));
    check("rst.full",         BITS'(bus.full),         '0);
    check("rst.almost_full",  BITS'(bus.almost_full),  '0);
    check("rst.almost_empty", BITS'(bus.almost_empty), BITS'(1));
    check("rst.q",            bus.q,                   '0);
    check("rst.overflow",     BITS'(bus.overflow),     '0);
    check("rst.underflow",    BITS'(bus.underflow),    '0);
    ref_q.delete();
    exp_q.delete();
    ref_ovf = 1'b0;
    ref_unf = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int pu_pct, po_pct;
    bus.flush = 1'b0;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.d     = '0;
    ref_ovf   = 1'b0;
    ref_unf   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_status("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // idle after reset
    idle(3);
    // fill to full, drain in order
    fill_11_88();
    pop_n(DEPTH);
    idle(1);
    // overflow while full, then flush clears it
    fill_11_88();
    push_val(BITS'('h99));
    idle(2);
    drive(1'b1, 1'b0, '0, 1'b0);
    idle(1);
    // full with simultaneous push/pop, then drain across the wrap
    fill_11_88();
    drive(1'b0, 1'b1, BITS'('hAA), 1'b1);
    idle(1);
    pop_n(DEPTH);
    idle(1);
    // empty with simultaneous push/pop: underflow, push accepted
    drive(1'b0, 1'b1, BITS'('h5), 1'b1);
    idle(1);
    pop_n(1);
    drive(1'b1, 1'b0, '0, 1'b0);
    // async reset with entries in flight
    push_val(BITS'('h1));
    push_val(BITS'('h2));
    push_val(BITS'('h3));
    async_reset();
    push_val(BITS'('h7));
    idle(1);
    pop_n(1);

    // random phase with shifting push/pop bias to reach full and empty often
    for (int seg = 0; seg < 6; seg++) begin
      pu_pct = (seg % 2 == 0) ? 75 : 25;
      po_pct = (seg % 2 == 0) ? 25 : 75;
      if (seg >= 4) begin
        pu_pct = 50;
        po_pct = 50;
      end
      for (int i = 0; i < 250; i++) begin
        drive($urandom_range(0, 99) == 0,
              $urandom_range(0, 99) < pu_pct,
              {$urandom(), $urandom()},
              $urandom_range(0, 99) < po_pct);
      end
    end
    idle(2);

    check("leftover_expected", BITS'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
